// File: rtl/cpu_fetch.sv
// rtl/cpu_fetch.sv - Rv32H instruction fetch stage with tagged issue and branch wait.
module cpu_fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'h00000000,
  parameter int          TAG_WIDTH    = 8
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_stall,
  output logic                 o_bus_request,
  output logic [31:0]          o_bus_address,
  input  logic                 i_bus_ready,
  input  logic [31:0]          i_bus_rdata,
  input  logic [TAG_WIDTH-1:0] i_branch_tag,
  input  logic [31:0]          i_branch_pc,
  output logic [TAG_WIDTH-1:0] o_tag,
  output logic [31:0]          o_instruction,
  output logic [31:0]          o_pc
);

  typedef enum logic [1:0] {FETCH, ISSUE, WAIT_BRANCH} state_t;

  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  state_t               state;
  logic [31:0]          pc;
  logic [31:0]          ibuf;
  logic                 pending;
  logic [TAG_WIDTH-1:0] branch_tag;

  logic                 slot_free;
  logic [TAG_WIDTH-1:0] tag_inc;
  logic [TAG_WIDTH-1:0] next_tag;
  logic                 is_control_flow;
  logic [31:0]          pc_plus4;
  logic [31:0]          redirect_pc;

  always_comb begin
    slot_free       = !pending || !i_stall;
    tag_inc         = o_tag + TAG_WIDTH'(1);
    // Tag 0 is reserved for "nothing issued", so the counter skips it on wrap.
    next_tag        = (tag_inc == '0) ? TAG_WIDTH'(1) : tag_inc;
    is_control_flow = (ibuf[6:0] == 7'b1100011) ||
                      (ibuf[6:0] == 7'b1101111) ||
                      (ibuf[6:0] == 7'b1100111);
    pc_plus4        = pc + 32'd4;
    redirect_pc     = i_branch_pc & WORD_MASK;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state         <= FETCH;
      pc            <= RESET_VECTOR;
      ibuf          <= '0;
      pending       <= 1'b0;
      branch_tag    <= '0;
      o_tag         <= '0;
      o_bus_request <= 1'b0;
      o_bus_address <= RESET_VECTOR & WORD_MASK;
      o_instruction <= '0;
      o_pc          <= '0;
    end else begin
      // Decode latches on every unstalled edge; an issue below re-arms the slot.
      if (!i_stall) begin
        pending <= 1'b0;
      end
      case (state)
        FETCH: begin
          if (!o_bus_request) begin
            o_bus_request <= 1'b1;
            o_bus_address <= pc & WORD_MASK;
          end else if (i_bus_ready) begin
            ibuf          <= i_bus_rdata;
            o_bus_request <= 1'b0;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          if (slot_free) begin
            o_instruction <= ibuf;
            o_pc          <= pc;
            o_tag         <= next_tag;
            pending       <= 1'b1;
            if (is_control_flow) begin
              branch_tag <= next_tag;
              state      <= WAIT_BRANCH;
            end else begin
              // Start the next request immediately to sustain two cycles per word.
              pc            <= pc_plus4;
              o_bus_request <= 1'b1;
              o_bus_address <= pc_plus4 & WORD_MASK;
              state         <= FETCH;
            end
          end
        end
        WAIT_BRANCH: begin
          if (i_branch_tag == branch_tag) begin
            pc            <= redirect_pc;
            o_bus_request <= 1'b1;
            o_bus_address <= redirect_pc;
            state         <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_fetch.sv
// tb/tb_cpu_fetch.sv - directed self-checking bench for cpu_fetch.
module tb_cpu_fetch;

  localparam logic [31:0] ADDI = 32'h00100093;
  localparam logic [31:0] BEQ  = 32'h00000063;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        bus_request;
  logic [31:0] bus_address;
  logic        bus_ready;
  logic [31:0] bus_rdata;
  logic [7:0]  branch_tag;
  logic [31:0] branch_pc;
  logic [7:0]  tag;
  logic [31:0] instruction;
  logic [31:0] pc;

  logic        rst2;
  logic        req2;
  logic [31:0] addr2;
  logic [1:0]  tag2;
  logic [31:0] instr2;
  logic [31:0] pc2;

  logic [31:0] mem [0:63];
  logic        mem_auto;
  logic        ready_manual;
  int          wait_states;
  int          wait_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign bus_ready = mem_auto ? (bus_request && (wait_cnt >= wait_states)) : ready_manual;
  assign bus_rdata = mem[bus_address[7:2]];

  always @(posedge clk) begin
    if (!bus_request || bus_ready) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  cpu_fetch #(.RESET_VECTOR(32'h0), .TAG_WIDTH(8)) dut (
    .i_clock(clk), .i_reset(rst), .i_stall(stall),
    .o_bus_request(bus_request), .o_bus_address(bus_address),
    .i_bus_ready(bus_ready), .i_bus_rdata(bus_rdata),
    .i_branch_tag(branch_tag), .i_branch_pc(branch_pc),
    .o_tag(tag), .o_instruction(instruction), .o_pc(pc)
  );

  cpu_fetch #(.RESET_VECTOR(32'h0), .TAG_WIDTH(2)) dut_wrap (
    .i_clock(clk), .i_reset(rst2), .i_stall(1'b0),
    .o_bus_request(req2), .o_bus_address(addr2),
    .i_bus_ready(req2), .i_bus_rdata(ADDI),
    .i_branch_tag(2'b00), .i_branch_pc(32'h0),
    .o_tag(tag2), .o_instruction(instr2), .o_pc(pc2)
  );

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_tag(input logic [7:0] t, input int bound);
    int c;
    c = 0;
    while (tag !== t && c < bound) begin
      @(negedge clk);
      c++;
    end
    checks++;
    if (tag !== t) begin
      errors++;
      $display("FAIL wait_tag timeout: got %0d need %0d", tag, t);
    end
  endtask

  task automatic test_reset;
    do_reset;
    checks++; if (tag !== 8'd0) begin errors++; $display("FAIL reset_tag got %0d need 0", tag); end
    checks++; if (bus_request !== 1'b0) begin errors++; $display("FAIL reset_req got %b need 0", bus_request); end
    checks++; if (bus_address !== 32'h0) begin errors++; $display("FAIL reset_addr got %h need 0", bus_address); end
    checks++; if (instruction !== 32'h0) begin errors++; $display("FAIL reset_instr got %h need 0", instruction); end
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h need 0", pc); end
  endtask

  task automatic test_straight;
    logic [31:0] addrs [$];
    logic [7:0]  tags  [3];
    logic [31:0] pcs   [3];
    int          cyc   [3];
    logic [7:0]  last_tag;
    logic [31:0] last_addr;
    logic        last_req;
    int          n;
    last_tag = 8'd0; last_req = 1'b0; last_addr = 32'h0; n = 0;
    for (int c = 0; c < 30 && n < 3; c++) begin
      @(negedge clk);
      if (bus_request && (!last_req || bus_address != last_addr)) addrs.push_back(bus_address);
      last_req = bus_request;
      last_addr = bus_address;
      if (tag != last_tag) begin
        tags[n] = tag; pcs[n] = pc; cyc[n] = c; n++;
        last_tag = tag;
      end
    end
    checks++;
    if (n != 3) begin
      errors++; $display("FAIL straight_count got %0d need 3", n);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (tags[i] !== 8'(i + 1)) begin errors++; $display("FAIL straight_tag%0d got %0d need %0d", i, tags[i], i + 1); end
        checks++;
        if (pcs[i] !== 32'(4 * i)) begin errors++; $display("FAIL straight_pc%0d got %h need %h", i, pcs[i], 4 * i); end
      end
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (cyc[i] - cyc[i-1] != 2) begin errors++; $display("FAIL straight_rate%0d got %0d need 2", i, cyc[i] - cyc[i-1]); end
      end
    end
    checks++;
    if (addrs.size() < 3) begin
      errors++; $display("FAIL straight_addr_count got %0d need 3", addrs.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (addrs[i] !== 32'(4 * i)) begin errors++; $display("FAIL straight_addr%0d got %h need %h", i, addrs[i], 4 * i); end
      end
    end
  endtask

  task automatic test_stall;
    do_reset;
    wait_tag(8'd2, 20);
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (tag !== 8'd2 || pc !== 32'h4 || instruction !== ADDI) begin
        errors++; $display("FAIL stall_hold%0d got tag %0d pc %h need tag 2 pc 4", i, tag, pc);
      end
    end
    stall = 1'b0;
    @(negedge clk);
    checks++;
    if (tag !== 8'd3 || pc !== 32'h8) begin
      errors++; $display("FAIL stall_release got tag %0d pc %h need tag 3 pc 8", tag, pc);
    end
  endtask

  task automatic test_branch;
    wait_tag(8'd5, 20);
    checks++; if (pc !== 32'h10) begin errors++; $display("FAIL branch_pc got %h need 10", pc); end
    checks++; if (instruction !== BEQ) begin errors++; $display("FAIL branch_instr got %h need %h", instruction, BEQ); end
    branch_tag = 8'd4;
    branch_pc = 32'h80;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (bus_request !== 1'b0) begin errors++; $display("FAIL branch_norequest%0d got %b need 0", i, bus_request); end
    end
    branch_tag = 8'd5;
    branch_pc = 32'h40;
    stall = 1'b1;
    @(negedge clk);
    branch_tag = 8'd0;
    stall = 1'b0;
    checks++;
    if (bus_request !== 1'b1 || bus_address !== 32'h40) begin
      errors++; $display("FAIL branch_redirect got req %b addr %h need req 1 addr 40", bus_request, bus_address);
    end
    wait_tag(8'd6, 20);
    checks++; if (pc !== 32'h40) begin errors++; $display("FAIL branch_target_pc got %h need 40", pc); end
  endtask

  task automatic test_wait_states;
    int req_cycles;
    logic bad_hold;
    logic seen;
    wait_states = 3;
    do_reset;
    req_cycles = 0; bad_hold = 1'b0; seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus_request) begin
        seen = 1'b1;
        req_cycles++;
        if (bus_address !== 32'h0) bad_hold = 1'b1;
      end else if (seen) begin
        break;
      end
    end
    checks++; if (req_cycles != 4) begin errors++; $display("FAIL wait_req_cycles got %0d need 4", req_cycles); end
    checks++; if (bad_hold) begin errors++; $display("FAIL wait_addr_hold got unstable need 0"); end
    wait_tag(8'd1, 10);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (tag !== 8'd1 || pc !== 32'h0) begin errors++; $display("FAIL wait_single_issue%0d got tag %0d need 1", i, tag); end
    end
    wait_states = 0;
  endtask

  task automatic test_tag_wrap;
    logic [1:0] seq [5];
    logic [1:0] last;
    logic       zero_seen;
    int         n;
    rst2 = 1'b0;
    last = 2'd0; n = 0; zero_seen = 1'b0;
    for (int c = 0; c < 40 && n < 5; c++) begin
      @(negedge clk);
      if (n > 0 && tag2 == 2'd0) zero_seen = 1'b1;
      if (tag2 != last) begin seq[n] = tag2; n++; last = tag2; end
    end
    checks++;
    if (n != 5) begin
      errors++; $display("FAIL wrap_count got %0d need 5", n);
    end else begin
      checks++;
      if (seq[0] !== 2'd1 || seq[1] !== 2'd2 || seq[2] !== 2'd3 || seq[3] !== 2'd1 || seq[4] !== 2'd2) begin
        errors++; $display("FAIL wrap_seq got %0d %0d %0d %0d %0d need 1 2 3 1 2", seq[0], seq[1], seq[2], seq[3], seq[4]);
      end
    end
    checks++; if (zero_seen) begin errors++; $display("FAIL wrap_zero got 0 need nonzero"); end
    rst2 = 1'b1;
  endtask

  task automatic test_reset_mid;
    int c;
    mem[4] = ADDI;
    do_reset;
    c = 0;
    while (!(bus_request === 1'b1 && bus_address === 32'h20) && c < 40) begin
      @(negedge clk);
      c++;
    end
    checks++;
    if (!(bus_request === 1'b1 && bus_address === 32'h20)) begin
      errors++; $display("FAIL mid_reach got addr %h need 20", bus_address);
    end
    mem_auto = 1'b0;
    ready_manual = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ready_manual = 1'b1;
    checks++; if (tag !== 8'd0) begin errors++; $display("FAIL mid_tag got %0d need 0", tag); end
    checks++; if (bus_request !== 1'b0) begin errors++; $display("FAIL mid_req got %b need 0", bus_request); end
    @(negedge clk);
    ready_manual = 1'b0;
    checks++;
    if (bus_request !== 1'b1 || bus_address !== 32'h0) begin
      errors++; $display("FAIL mid_refetch got req %b addr %h need req 1 addr 0", bus_request, bus_address);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (tag !== 8'd0) begin errors++; $display("FAIL mid_late_ready%0d got tag %0d need 0", i, tag); end
    end
    mem_auto = 1'b1;
    wait_tag(8'd1, 20);
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL mid_first_pc got %h need 0", pc); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = ADDI;
    mem[4] = BEQ;
    rst = 1'b1; rst2 = 1'b1; stall = 1'b0;
    branch_tag = 8'd0; branch_pc = 32'h0;
    mem_auto = 1'b1; ready_manual = 1'b0; wait_states = 0;
    test_reset;
    test_straight;
    test_stall;
    test_branch;
    test_wait_states;
    test_tag_wrap;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
